// File: rtl/cfg_sel_loader.sv
// cfg_sel_loader: serial config loader that commits checked select fields to the mux fabric atomically
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   cfg_start             pulse that begins or restarts a load (ignored in CHECK)
//   cfg_valid, cfg_bit    serial frame, MSB-first, TOTAL data bits then one even-parity bit
//   cfg_ready             high in LOAD only
//   sel_out               active selects, mux i at [i*SEL_WIDTH +: SEL_WIDTH]
//   cfg_busy              high in LOAD or CHECK
//   cfg_done              one-cycle pulse on a successful commit
//   cfg_err               sticky parity/range error of the last load
module cfg_sel_loader #(
    parameter int NUM_MUX   = 8,
    parameter int SEL_WIDTH = 4,
    parameter int MAX_SEL   = 9
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         cfg_start,
    input  logic                         cfg_valid,
    input  logic                         cfg_bit,
    output logic                         cfg_ready,
    output logic [NUM_MUX*SEL_WIDTH-1:0] sel_out,
    output logic                         cfg_busy,
    output logic                         cfg_done,
    output logic                         cfg_err
);
    localparam int TOTAL = NUM_MUX * SEL_WIDTH;
    localparam int CW = $clog2(TOTAL + 1);
    localparam logic [CW-1:0] LAST = CW'(TOTAL);
    localparam logic [SEL_WIDTH-1:0] MAX_F = SEL_WIDTH'(MAX_SEL);

    typedef enum logic [1:0] {IDLE, LOAD, CHECK} state_t;

    state_t           state, next;
    logic [CW-1:0]    cnt;
    logic [TOTAL-1:0] shadow;
    logic             par, ok_par, ok_rng, take;

    // a start pulse in LOAD wins over a coincident bit, so the restarted frame begins cleanly
    assign take      = state == LOAD && cfg_valid && !cfg_start;
    assign cfg_ready = state == LOAD;
    assign cfg_busy  = state != IDLE;
    assign ok_par    = ~^{shadow, par};

    always_comb begin
        ok_rng = 1'b1;
        for (int i = 0; i < NUM_MUX; i++)
            if (shadow[i*SEL_WIDTH +: SEL_WIDTH] > MAX_F) ok_rng = 1'b0;
    end

    always_comb begin
        next = state == IDLE ? (cfg_start ? LOAD : IDLE) :
               state == LOAD ? ((take && cnt == LAST) ? CHECK : LOAD) : IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            shadow   <= '0;
            par      <= 1'b0;
            sel_out  <= '0;
            cfg_done <= 1'b0;
            cfg_err  <= 1'b0;
        end else begin
            cfg_done <= 1'b0;
            if (cfg_start && state != CHECK) begin
                cnt     <= '0;
                cfg_err <= 1'b0;
            end else if (take) begin
                if (cnt == LAST) par <= cfg_bit;
                else begin
                    shadow <= {shadow[TOTAL-2:0], cfg_bit};
                    cnt    <= cnt + 1'b1;
                end
            end else if (state == CHECK) begin
                if (ok_par && ok_rng) begin
                    sel_out  <= shadow;
                    cfg_done <= 1'b1;
                end else cfg_err <= 1'b1;
            end
        end
    end
endmodule
